// File: rtl/core_wb_master_bridge.sv
// Bridges a level-request core port onto a single-outstanding Wishbone B4 pipelined master.
// state | meaning: IDLE wait for request | REQ stb driven | WAIT await ack/err | RESP response pulse
module core_wb_master_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter logic [31:0] ERR_RDATA      = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] core_addr,
  input  logic [31:0] core_wdata,
  input  logic [3:0]  core_wstrb,
  input  logic        core_read_request,
  input  logic        core_write_request,
  output logic [31:0] core_rdata,
  output logic        core_read_response,
  output logic        core_write_response,
  output logic        core_error,
  output logic        wb_cyc,
  output logic        wb_stb,
  output logic        wb_we,
  output logic [3:0]  wb_sel,
  output logic [31:0] wb_adr,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack,
  input  logic        wb_err,
  input  logic        wb_stall
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_RESP = 2'd3;

  localparam logic [15:0] TMO_LIMIT = TIMEOUT_CYCLES[15:0];

  logic [1:0]  state;
  logic [15:0] tmo_cnt;
  logic [15:0] tmo_next;
  logic        is_write;
  logic        tmo_hit;
  logic        complete;
  logic        complete_err;

  assign tmo_next = tmo_cnt + 16'd1;
  assign tmo_hit  = (tmo_next == TMO_LIMIT);

  // A bus response takes priority over a timeout landing on the same edge.
  always_comb begin
    complete     = 1'b0;
    complete_err = 1'b0;
    case (state)
      ST_REQ: begin
        if (!wb_stall && (wb_ack || wb_err)) begin
          complete     = 1'b1;
          complete_err = wb_err;
        end else if (tmo_hit) begin
          complete     = 1'b1;
          complete_err = 1'b1;
        end
      end
      ST_WAIT: begin
        if (wb_ack || wb_err) begin
          complete     = 1'b1;
          complete_err = wb_err;
        end else if (tmo_hit) begin
          complete     = 1'b1;
          complete_err = 1'b1;
        end
      end
      default: begin
        complete     = 1'b0;
        complete_err = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= ST_IDLE;
      tmo_cnt             <= 16'd0;
      is_write            <= 1'b0;
      core_rdata          <= 32'd0;
      core_read_response  <= 1'b0;
      core_write_response <= 1'b0;
      core_error          <= 1'b0;
      wb_cyc              <= 1'b0;
      wb_stb              <= 1'b0;
      wb_we               <= 1'b0;
      wb_sel              <= 4'd0;
      wb_adr              <= 32'd0;
      wb_dat_o            <= 32'd0;
    end else begin
      core_read_response  <= 1'b0;
      core_write_response <= 1'b0;
      case (state)
        ST_IDLE: begin
          // A simultaneous read stays asserted by the core and is picked up after the write.
          if (core_read_request || core_write_request) begin
            state    <= ST_REQ;
            tmo_cnt  <= 16'd0;
            is_write <= core_write_request;
            wb_we    <= core_write_request;
            wb_sel   <= core_write_request ? core_wstrb : 4'hF;
            wb_adr   <= core_addr;
            wb_dat_o <= core_wdata;
            wb_cyc   <= 1'b1;
            wb_stb   <= 1'b1;
          end
        end
        ST_REQ, ST_WAIT: begin
          if (complete) begin
            state               <= ST_RESP;
            wb_cyc              <= 1'b0;
            wb_stb              <= 1'b0;
            core_error          <= complete_err;
            core_write_response <= is_write;
            core_read_response  <= !is_write;
            if (!is_write) begin
              core_rdata <= complete_err ? ERR_RDATA : wb_dat_i;
            end
          end else begin
            tmo_cnt <= tmo_next;
            if (state == ST_REQ && !wb_stall) begin
              state  <= ST_WAIT;
              wb_stb <= 1'b0;
            end
          end
        end
        default: begin
          state      <= ST_IDLE;
          core_error <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_core_wb_master_bridge.sv
// Randomized bench: the driver plays core and Wishbone slave, a monitor scores responses from a queue.
module tb_core_wb_master_bridge;

  localparam int          TMO  = 8;
  localparam logic [31:0] ERRD = 32'hDEAD_BEEF;

  logic        clk;
  logic        rst_n;
  logic [31:0] core_addr;
  logic [31:0] core_wdata;
  logic [3:0]  core_wstrb;
  logic        core_read_request;
  logic        core_write_request;
  logic [31:0] core_rdata;
  logic        core_read_response;
  logic        core_write_response;
  logic        core_error;
  logic        wb_cyc;
  logic        wb_stb;
  logic        wb_we;
  logic [3:0]  wb_sel;
  logic [31:0] wb_adr;
  logic [31:0] wb_dat_o;
  logic [31:0] wb_dat_i;
  logic        wb_ack;
  logic        wb_err;
  logic        wb_stall;

  core_wb_master_bridge #(.TIMEOUT_CYCLES(TMO), .ERR_RDATA(ERRD)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .core_addr           (core_addr),
    .core_wdata          (core_wdata),
    .core_wstrb          (core_wstrb),
    .core_read_request   (core_read_request),
    .core_write_request  (core_write_request),
    .core_rdata          (core_rdata),
    .core_read_response  (core_read_response),
    .core_write_response (core_write_response),
    .core_error          (core_error),
    .wb_cyc              (wb_cyc),
    .wb_stb              (wb_stb),
    .wb_we               (wb_we),
    .wb_sel              (wb_sel),
    .wb_adr              (wb_adr),
    .wb_dat_o            (wb_dat_o),
    .wb_dat_i            (wb_dat_i),
    .wb_ack              (wb_ack),
    .wb_err              (wb_err),
    .wb_stall            (wb_stall)
  );

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_rdata = 32'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d errors %0d", checks, errors);
    $fatal(1);
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every response pulse must match the oldest expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (core_read_response || core_write_response) begin
        check("resp_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) begin
          exp_t e;
          e = exp_q.pop_front();
          check("resp_write_dir", 32'(core_write_response), 32'(e.wr));
          check("resp_read_dir", 32'(core_read_response), 32'(!e.wr));
          check("resp_error", 32'(core_error), 32'(e.err));
          check("resp_rdata", core_rdata, e.rdata);
        end
      end else begin
        check("error_outside_resp", 32'(core_error), 32'd0);
      end
    end
  end

  // kind: 0 ack, 1 err, 2 ack+err, 3 no response (timeout).
  task automatic run_txn(input bit rd, input bit wr, input logic [31:0] adr, input logic [31:0] wd,
                         input logic [3:0] strb, input int stall_n, input int ack_delay,
                         input int kind, input logic [31:0] rdat, input int exp_lat);
    int   fin;
    int   exp_len;
    int   lat;
    int   k;
    bit   resp;
    exp_t e;
    fin     = stall_n + 1 + ack_delay;
    exp_len = (kind == 3) ? TMO : fin;
    if (!wr) model_rdata = (kind == 0) ? rdat : ERRD;
    e.wr    = wr;
    e.err   = (kind != 0);
    e.rdata = model_rdata;
    exp_q.push_back(e);

    core_read_request  = rd;
    core_write_request = wr;
    core_addr          = adr;
    core_wdata         = wd;
    core_wstrb         = strb;
    wb_ack             = 1'b0;
    wb_err             = 1'b0;
    wb_stall           = 1'b0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!wb_cyc && lat < 6);
    check("start_latency", 32'(lat), 32'(exp_lat));
    if (wb_cyc) begin
      k = 1;
      while (wb_cyc && k <= 20) begin
        resp     = (kind != 3) && (k == fin);
        wb_stall = (k <= stall_n);
        wb_ack   = resp && (kind != 1);
        wb_err   = resp && (kind != 0);
        wb_dat_i = wb_ack ? rdat : $urandom;
        check("stb_level", 32'(wb_stb), 32'(k <= stall_n + 1));
        check("we", 32'(wb_we), 32'(wr));
        check("sel", 32'(wb_sel), wr ? 32'(strb) : 32'hF);
        check("adr", wb_adr, adr);
        if (wr) check("dat_o", wb_dat_o, wd);
        @(posedge clk); #1;
        k++;
      end
      wb_ack   = 1'b0;
      wb_err   = 1'b0;
      wb_stall = 1'b0;
      check("cyc_cycles", 32'(k - 1), 32'(exp_len));
      check("resp_on_cyc_drop", 32'(wr ? core_write_response : core_read_response), 32'd1);
    end
    if (wr) core_write_request = 1'b0;
    else    core_read_request  = 1'b0;
  endtask

  task automatic idle(input int n, input bit spurious);
    for (int i = 0; i < n; i++) begin
      wb_ack   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      wb_err   = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
      wb_dat_i = $urandom;
      @(posedge clk); #1;
      check("idle_cyc", 32'(wb_cyc), 32'd0);
      check("idle_rdata_hold", core_rdata, model_rdata);
    end
    wb_ack = 1'b0;
    wb_err = 1'b0;
  endtask

  task automatic both_txn(input logic [31:0] adr, input logic [31:0] wd, input logic [3:0] strb,
                          input int s1, input int d1, input int k1,
                          input int s2, input int d2, input int k2, input logic [31:0] rdat);
    run_txn(1'b1, 1'b1, adr, wd, strb, s1, d1, k1, 32'd0, 1);
    run_txn(1'b1, 1'b0, adr, wd, strb, s2, d2, k2, rdat, 2);
  endtask

  initial begin
    rst_n = 1'b0;
    core_addr = '0; core_wdata = '0; core_wstrb = '0;
    core_read_request = 1'b0; core_write_request = 1'b0;
    wb_dat_i = '0; wb_ack = 1'b0; wb_err = 1'b0; wb_stall = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cyc", 32'(wb_cyc), 32'd0);
    check("rst_stb", 32'(wb_stb), 32'd0);
    check("rst_we", 32'(wb_we), 32'd0);
    check("rst_sel", 32'(wb_sel), 32'd0);
    check("rst_adr", wb_adr, 32'd0);
    check("rst_dat_o", wb_dat_o, 32'd0);
    check("rst_rdata", core_rdata, 32'd0);
    check("rst_resp", 32'({core_read_response, core_write_response, core_error}), 32'd0);
    rst_n = 1'b1;
    idle(2, 1'b0);

    run_txn(1'b1, 1'b0, 32'h100, 32'h0, 4'h0, 0, 1, 0, 32'hCAFE_F00D, 1);
    idle(1, 1'b0);
    run_txn(1'b0, 1'b1, 32'h200, 32'h1234_5678, 4'b0011, 3, 1, 0, 32'h0, 1);
    idle(2, 1'b0);
    run_txn(1'b1, 1'b0, 32'h300, 32'h0, 4'h0, 0, 0, 3, 32'h0, 1);
    idle(1, 1'b0);
    run_txn(1'b1, 1'b0, 32'h304, 32'h0, 4'h0, 0, 1, 2, 32'h5555_AAAA, 1);
    idle(6, 1'b1);
    run_txn(1'b1, 1'b0, 32'h308, 32'h0, 4'h0, 2, 0, 0, 32'h0BAD_F00D, 1);
    idle(1, 1'b0);
    run_txn(1'b0, 1'b1, 32'h30C, 32'hA5A5_5A5A, 4'b1000, 1, 2, 1, 32'h0, 1);
    idle(1, 1'b0);
    run_txn(1'b1, 1'b0, 32'h310, 32'h0, 4'h0, 12, 0, 3, 32'h0, 1);
    idle(1, 1'b0);
    both_txn(32'h400, 32'hFEED_BEEF, 4'b1111, 0, 1, 0, 1, 0, 0, 32'h7777_1234);
    idle(2, 1'b0);

    // Reset while the slave never answers: cyc must drop and no response may follow.
    core_read_request = 1'b1;
    core_addr = 32'h500;
    @(posedge clk); #1;
    check("pre_rst_cyc", 32'(wb_cyc), 32'd1);
    @(posedge clk); #1;
    check("pre_rst_wait_stb", 32'(wb_stb), 32'd0);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_cyc", 32'(wb_cyc), 32'd0);
    check("mid_rst_stb", 32'(wb_stb), 32'd0);
    check("mid_rst_resp", 32'(core_read_response), 32'd0);
    check("mid_rst_rdata", core_rdata, 32'd0);
    model_rdata = 32'd0;
    core_read_request = 1'b0;
    rst_n = 1'b1;
    idle(TMO + 4, 1'b0);

    for (int t = 0; t < 40; t++) begin
      int          op;
      int          kr;
      int          kind;
      int          st;
      int          kind2;
      logic [31:0] a;
      logic [31:0] wd;
      logic [31:0] rd;
      op   = $urandom_range(0, 2);
      kr   = $urandom_range(0, 5);
      kind = (kr < 3) ? 0 : kr - 2;
      st   = (kind == 3) ? $urandom_range(0, 10) : $urandom_range(0, 3);
      a    = $urandom;
      wd   = $urandom;
      rd   = $urandom;
      if (op == 0) begin
        run_txn(1'b1, 1'b0, a, wd, 4'($urandom), st, $urandom_range(0, 3), kind, rd, 1);
      end else if (op == 1) begin
        run_txn(1'b0, 1'b1, a, wd, 4'($urandom), st, $urandom_range(0, 3), kind, rd, 1);
      end else begin
        kr    = $urandom_range(0, 5);
        kind2 = (kr < 3) ? 0 : kr - 2;
        both_txn(a, wd, 4'($urandom), st, $urandom_range(0, 3), kind,
                 $urandom_range(0, 3), $urandom_range(0, 3), kind2, rd);
      end
      idle($urandom_range(1, 3), 1'($urandom_range(0, 1)));
    end

    idle(3, 1'b0);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
